// File: rtl/core8_mem_arbiter.sv
// Round-robin arbiter sharing one single-port on-chip memory between several Avalon-MM masters.
// Grants are combinational; read data returns one cycle after issue to the granting master.
module core8_mem_arbiter #(
    parameter int NUM_MASTERS = 4,
    parameter int ADDR_W      = 13,
    parameter int DATA_W      = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          mem_reset_req,
    input  logic [NUM_MASTERS*ADDR_W-1:0] s_address,
    input  logic [NUM_MASTERS*DATA_W/8-1:0] s_byteenable,
    input  logic [NUM_MASTERS-1:0]        s_read,
    input  logic [NUM_MASTERS-1:0]        s_write,
    input  logic [NUM_MASTERS*DATA_W-1:0] s_writedata,
    output logic [NUM_MASTERS-1:0]        s_waitrequest,
    output logic [DATA_W-1:0]             s_readdata,
    output logic [NUM_MASTERS-1:0]        s_readdatavalid,
    output logic [ADDR_W-1:0]             mem_address,
    output logic [DATA_W/8-1:0]           mem_byteenable,
    output logic                          mem_chipselect,
    output logic                          mem_write,
    output logic [DATA_W-1:0]             mem_writedata,
    output logic                          mem_clken,
    input  logic [DATA_W-1:0]             mem_readdata
);

    localparam int BE_W  = DATA_W / 8;
    localparam int PTR_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    logic [NUM_MASTERS-1:0] req_s;
    logic [NUM_MASTERS-1:0] grant_s;
    logic                   grant_valid_s;
    logic [PTR_W-1:0]       grant_idx_s;
    logic [PTR_W-1:0]       idx_s;
    logic                   grant_read_s;

    logic [PTR_W-1:0]       rr_ptr_r;
    logic                   rd_pending_r;
    logic [PTR_W-1:0]       rd_owner_r;

    // Round-robin search starting at rr_ptr, blocked while either reset is active.
    always_comb begin
        req_s         = s_read | s_write;
        grant_s       = '0;
        grant_valid_s = 1'b0;
        grant_idx_s   = '0;
        idx_s         = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            idx_s = PTR_W'((int'(rr_ptr_r) + k) % NUM_MASTERS);
            if (!grant_valid_s && req_s[idx_s] && !reset && !mem_reset_req) begin
                grant_valid_s = 1'b1;
                grant_idx_s   = idx_s;
            end else begin
                grant_valid_s = grant_valid_s;
            end
        end
        if (grant_valid_s) begin
            grant_s[grant_idx_s] = 1'b1;
        end else begin
            grant_s = '0;
        end
        s_waitrequest = req_s & ~grant_s;
    end

    // Memory-side mux; a write wins over a simultaneous read from the same master.
    always_comb begin
        mem_address    = '0;
        mem_byteenable = '0;
        mem_writedata  = '0;
        mem_chipselect = 1'b0;
        mem_write      = 1'b0;
        grant_read_s   = 1'b0;
        if (grant_valid_s) begin
            mem_address    = s_address[grant_idx_s*ADDR_W +: ADDR_W];
            mem_byteenable = s_byteenable[grant_idx_s*BE_W +: BE_W];
            mem_writedata  = s_writedata[grant_idx_s*DATA_W +: DATA_W];
            mem_chipselect = 1'b1;
            mem_write      = s_write[grant_idx_s];
            grant_read_s   = s_read[grant_idx_s] & ~s_write[grant_idx_s];
        end else begin
            mem_chipselect = 1'b0;
        end
    end

    // Read return strobe; suppressed while the memory clock is frozen.
    always_comb begin
        s_readdatavalid = '0;
        if (rd_pending_r && !mem_reset_req) begin
            s_readdatavalid[rd_owner_r] = 1'b1;
        end else begin
            s_readdatavalid = '0;
        end
    end

    assign s_readdata = mem_readdata;
    assign mem_clken  = ~mem_reset_req;

    // Pointer and outstanding-read tracking.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_r     <= '0;
            rd_pending_r <= 1'b0;
            rd_owner_r   <= '0;
        end else if (grant_valid_s) begin
            rr_ptr_r     <= (grant_idx_s == PTR_W'(NUM_MASTERS - 1)) ? '0 : grant_idx_s + PTR_W'(1);
            rd_pending_r <= grant_read_s;
            rd_owner_r   <= grant_read_s ? grant_idx_s : rd_owner_r;
        end else begin
            rd_pending_r <= 1'b0;
        end
    end

endmodule

// File: tb/tb_core8_mem_arbiter.sv
// Bench for core8_mem_arbiter: directed scenarios plus randomized traffic against a
// cycle-level reference model with its own golden memory image.
module tb_core8_mem_arbiter;

    localparam int N  = 4;
    localparam int AW = 13;
    localparam int DW = 32;
    localparam int BW = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            mem_reset_req;
    logic [N*AW-1:0] s_address;
    logic [N*BW-1:0] s_byteenable;
    logic [N-1:0]    s_read;
    logic [N-1:0]    s_write;
    logic [N*DW-1:0] s_writedata;
    logic [N-1:0]    s_waitrequest;
    logic [DW-1:0]   s_readdata;
    logic [N-1:0]    s_readdatavalid;
    logic [AW-1:0]   mem_address;
    logic [BW-1:0]   mem_byteenable;
    logic            mem_chipselect;
    logic            mem_write;
    logic [DW-1:0]   mem_writedata;
    logic            mem_clken;
    logic [DW-1:0]   mem_readdata;

    int n_tests = 0;
    int n_fail  = 0;

    core8_mem_arbiter #(.NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset), .mem_reset_req(mem_reset_req),
        .s_address(s_address), .s_byteenable(s_byteenable), .s_read(s_read),
        .s_write(s_write), .s_writedata(s_writedata), .s_waitrequest(s_waitrequest),
        .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_clken(mem_clken), .mem_readdata(mem_readdata)
    );

    always #5 clk = ~clk;

    // Memory: registered q, one cycle read latency, gated by clken.
    logic [DW-1:0] ram [0:8191] = '{default: 32'h0};
    logic [DW-1:0] ram_q = 32'h0;
    always @(posedge clk) begin
        if (mem_clken && mem_chipselect) begin
            if (mem_write) begin
                for (int b = 0; b < BW; b++)
                    if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
            end else begin
                ram_q <= ram[mem_address];
            end
        end
    end
    assign mem_readdata = ram_q;

    // Reference model state
    logic [DW-1:0] gold [0:8191] = '{default: 32'h0};
    int            m_ptr = 0;
    int            m_owner = 0;
    bit            m_pend = 1'b0;
    logic [DW-1:0] m_data = 32'h0;
    int            exp_g = -1;
    logic [N-1:0]  exp_wait, exp_rdv;
    logic          exp_cs, exp_we;
    logic [AW-1:0] exp_addr;
    logic [BW-1:0] exp_be;
    logic [DW-1:0] exp_wd;

    task automatic model_eval();
        int idx;
        if (reset) begin
            m_ptr = 0; m_pend = 1'b0; m_owner = 0;
        end
        exp_g = -1;
        if (!reset && !mem_reset_req) begin
            for (int k = 0; k < N; k++) begin
                idx = (m_ptr + k) % N;
                if (exp_g < 0 && (s_read[idx] || s_write[idx])) exp_g = idx;
            end
        end
        exp_wait = s_read | s_write;
        if (exp_g >= 0) exp_wait[exp_g] = 1'b0;
        exp_rdv = '0;
        if (m_pend && !mem_reset_req) exp_rdv[m_owner] = 1'b1;
        exp_cs   = (exp_g >= 0);
        exp_we   = (exp_g >= 0) ? s_write[exp_g] : 1'b0;
        exp_addr = (exp_g >= 0) ? s_address[exp_g*AW +: AW] : '0;
        exp_be   = (exp_g >= 0) ? s_byteenable[exp_g*BW +: BW] : '0;
        exp_wd   = (exp_g >= 0) ? s_writedata[exp_g*DW +: DW] : '0;
    endtask

    task automatic model_commit();
        logic [AW-1:0] a;
        if (reset) begin
            m_ptr = 0; m_pend = 1'b0; m_owner = 0;
        end else if (exp_g >= 0) begin
            a = s_address[exp_g*AW +: AW];
            if (s_write[exp_g]) begin
                for (int b = 0; b < BW; b++)
                    if (s_byteenable[exp_g*BW + b]) gold[a][8*b +: 8] = s_writedata[exp_g*DW + 8*b +: 8];
                m_pend = 1'b0;
            end else begin
                m_pend  = 1'b1;
                m_owner = exp_g;
                m_data  = gold[a];
            end
            m_ptr = (exp_g + 1) % N;
        end else begin
            m_pend = 1'b0;
        end
    endtask

    // Model evaluates 1 time unit after inputs change on the falling edge; commits at the rising edge.
    always begin
        @(negedge clk);
        #1;
        model_eval();
    end
    always @(posedge clk) model_commit();

    task automatic set_m(input int i, input logic rd, input logic wr, input logic [AW-1:0] a,
                         input logic [BW-1:0] be, input logic [DW-1:0] d);
        s_read[i] = rd;
        s_write[i] = wr;
        s_address[i*AW +: AW] = a;
        s_byteenable[i*BW +: BW] = be;
        s_writedata[i*DW +: DW] = d;
    endtask

    task automatic clr_all();
        s_read = '0; s_write = '0; s_address = '0; s_byteenable = '0; s_writedata = '0;
    endtask

    task automatic test_reset();
        @(negedge clk); clr_all(); #2;
        n_tests++; if (mem_chipselect !== 1'b0) begin n_fail++; $display("FAIL reset_cs got %b want 0", mem_chipselect); end
        n_tests++; if (s_waitrequest !== 4'b0000) begin n_fail++; $display("FAIL reset_wait got %b want 0000", s_waitrequest); end
        n_tests++; if (s_readdatavalid !== 4'b0000) begin n_fail++; $display("FAIL reset_rdv got %b want 0000", s_readdatavalid); end
        n_tests++; if (mem_address !== 13'h0 || mem_clken !== 1'b1) begin n_fail++; $display("FAIL reset_idle addr %h clken %b want 0/1", mem_address, mem_clken); end
        @(negedge clk); s_read = 4'b1111; #2;
        n_tests++; if (s_waitrequest !== 4'b1111) begin n_fail++; $display("FAIL reset_nogrant got %b want 1111", s_waitrequest); end
        @(negedge clk); clr_all(); reset = 1'b0;
    endtask

    task automatic test_single_write_read();
        @(negedge clk); clr_all(); set_m(0, 1'b0, 1'b1, 13'h0010, 4'hF, 32'hDEADBEEF); #2;
        n_tests++; if (s_waitrequest !== 4'b0000 || mem_chipselect !== 1'b1 || mem_write !== 1'b1) begin
            n_fail++; $display("FAIL swr_write wait %b cs %b we %b want 0000/1/1", s_waitrequest, mem_chipselect, mem_write); end
        n_tests++; if (mem_address !== 13'h0010 || mem_writedata !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL swr_wmux addr %h data %h want 0010/deadbeef", mem_address, mem_writedata); end
        @(negedge clk); set_m(0, 1'b1, 1'b0, 13'h0010, 4'hF, 32'h0); #2;
        n_tests++; if (s_waitrequest !== 4'b0000 || mem_write !== 1'b0) begin
            n_fail++; $display("FAIL swr_read wait %b we %b want 0000/0", s_waitrequest, mem_write); end
        @(negedge clk); clr_all(); #2;
        n_tests++; if (s_readdatavalid !== 4'b0001) begin n_fail++; $display("FAIL swr_rdv got %b want 0001", s_readdatavalid); end
        n_tests++; if (s_readdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL swr_data got %h want deadbeef", s_readdata); end
        @(negedge clk); #2;
        n_tests++; if (s_readdatavalid !== 4'b0000) begin n_fail++; $display("FAIL swr_rdv_once got %b want 0000", s_readdatavalid); end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] want;
        for (int i = 0; i < N; i++) begin
            @(negedge clk); clr_all(); set_m(i, 1'b0, 1'b1, 13'h100 + 13'(i), 4'hF, 32'hA5000000 + 32'(i));
        end
        @(negedge clk); clr_all(); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) set_m(i, 1'b1, 1'b0, 13'h100 + 13'(i), 4'hF, 32'h0);
            #2;
            want = ~(4'b0001 << (k % N));
            n_tests++; if (s_waitrequest !== want || mem_chipselect !== 1'b1) begin
                n_fail++; $display("FAIL rr_grant cyc %0d wait %b cs %b want %b/1", k, s_waitrequest, mem_chipselect, want); end
            if (k >= 1) begin
                n_tests++; if (s_readdatavalid !== (4'b0001 << ((k - 1) % N)) || s_readdata !== 32'hA5000000 + 32'((k - 1) % N)) begin
                    n_fail++; $display("FAIL rr_return cyc %0d rdv %b data %h want %b/%h", k, s_readdatavalid, s_readdata,
                                       4'b0001 << ((k - 1) % N), 32'hA5000000 + 32'((k - 1) % N)); end
            end
        end
        @(negedge clk); clr_all(); #2;
        n_tests++; if (s_readdatavalid !== 4'b1000 || s_readdata !== 32'hA5000003) begin
            n_fail++; $display("FAIL rr_last rdv %b data %h want 1000/a5000003", s_readdatavalid, s_readdata); end
    endtask

    task automatic test_byte_lane();
        @(negedge clk); clr_all(); set_m(2, 1'b0, 1'b1, 13'h1FFF, 4'hF, 32'h11223344);
        @(negedge clk); set_m(2, 1'b0, 1'b1, 13'h1FFF, 4'h1, 32'h000000AA); #2;
        n_tests++; if (mem_byteenable !== 4'h1 || mem_address !== 13'h1FFF) begin
            n_fail++; $display("FAIL bl_mux be %h addr %h want 1/1fff", mem_byteenable, mem_address); end
        @(negedge clk); set_m(2, 1'b1, 1'b0, 13'h1FFF, 4'hF, 32'h0);
        @(negedge clk); clr_all(); #2;
        n_tests++; if (s_readdatavalid !== 4'b0100 || s_readdata !== 32'h112233AA) begin
            n_fail++; $display("FAIL bl_read rdv %b data %h want 0100/112233aa", s_readdatavalid, s_readdata); end
    endtask

    task automatic test_simultaneous();
        @(negedge clk); clr_all(); set_m(1, 1'b0, 1'b1, 13'h0020, 4'hF, 32'h1);
        @(negedge clk); clr_all();
        set_m(1, 1'b0, 1'b1, 13'h0021, 4'hF, 32'h11);
        set_m(3, 1'b0, 1'b1, 13'h0023, 4'hF, 32'h33); #2;
        n_tests++; if (s_waitrequest !== 4'b0010 || mem_address !== 13'h0023) begin
            n_fail++; $display("FAIL sim_first wait %b addr %h want 0010/0023", s_waitrequest, mem_address); end
        @(negedge clk); set_m(3, 1'b0, 1'b0, 13'h0, 4'h0, 32'h0); #2;
        n_tests++; if (s_waitrequest !== 4'b0000 || mem_address !== 13'h0021) begin
            n_fail++; $display("FAIL sim_second wait %b addr %h want 0000/0021", s_waitrequest, mem_address); end
        @(negedge clk); clr_all();
        set_m(1, 1'b0, 1'b1, 13'h0031, 4'hF, 32'h1);
        set_m(2, 1'b0, 1'b1, 13'h0032, 4'hF, 32'h2); #2;
        n_tests++; if (s_waitrequest !== 4'b0010) begin
            n_fail++; $display("FAIL sim_ptr2 wait %b want 0010", s_waitrequest); end
        @(negedge clk); clr_all();
    endtask

    task automatic test_mem_reset_req();
        @(negedge clk); clr_all(); set_m(0, 1'b1, 1'b0, 13'h0010, 4'hF, 32'h0); #2;
        n_tests++; if (s_waitrequest !== 4'b0000) begin n_fail++; $display("FAIL mrr_issue wait %b want 0000", s_waitrequest); end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); clr_all(); set_m(1, 1'b1, 1'b0, 13'h0101, 4'hF, 32'h0); mem_reset_req = 1'b1; #2;
            n_tests++; if (s_readdatavalid !== 4'b0000 || mem_clken !== 1'b0) begin
                n_fail++; $display("FAIL mrr_frozen cyc %0d rdv %b clken %b want 0000/0", c, s_readdatavalid, mem_clken); end
            n_tests++; if (s_waitrequest !== 4'b0010 || mem_chipselect !== 1'b0) begin
                n_fail++; $display("FAIL mrr_block cyc %0d wait %b cs %b want 0010/0", c, s_waitrequest, mem_chipselect); end
        end
        @(negedge clk); mem_reset_req = 1'b0; #2;
        n_tests++; if (s_waitrequest !== 4'b0000 || mem_address !== 13'h0101 || mem_clken !== 1'b1) begin
            n_fail++; $display("FAIL mrr_release wait %b addr %h clken %b want 0000/0101/1", s_waitrequest, mem_address, mem_clken); end
        @(negedge clk); clr_all(); #2;
        n_tests++; if (s_readdatavalid !== 4'b0010 || s_readdata !== 32'hA5000001) begin
            n_fail++; $display("FAIL mrr_return rdv %b data %h want 0010/a5000001", s_readdatavalid, s_readdata); end
    endtask

    task automatic test_reset_mid_read();
        @(negedge clk); clr_all(); set_m(0, 1'b1, 1'b0, 13'h0010, 4'hF, 32'h0); #2;
        n_tests++; if (s_waitrequest !== 4'b0000) begin n_fail++; $display("FAIL rmr_issue wait %b want 0000", s_waitrequest); end
        @(negedge clk); clr_all(); reset = 1'b1; #2;
        n_tests++; if (s_readdatavalid !== 4'b0000 || mem_chipselect !== 1'b0) begin
            n_fail++; $display("FAIL rmr_drop rdv %b cs %b want 0000/0", s_readdatavalid, mem_chipselect); end
        @(negedge clk); reset = 1'b0; #2;
        n_tests++; if (s_readdatavalid !== 4'b0000) begin n_fail++; $display("FAIL rmr_after rdv %b want 0000", s_readdatavalid); end
        @(negedge clk); s_read = 4'b1111; #2;
        n_tests++; if (s_waitrequest !== 4'b1110) begin n_fail++; $display("FAIL rmr_ptr0 wait %b want 1110", s_waitrequest); end
        @(negedge clk); clr_all();
    endtask

    task automatic test_random();
        bit act [N];
        int kind;
        for (int i = 0; i < N; i++) act[i] = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (!act[i]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        act[i] = 1'b1;
                        kind = $urandom_range(0, 2);
                        set_m(i, kind != 1, kind != 0, 13'($urandom_range(0, 31)), 4'($urandom_range(1, 15)), $urandom);
                    end else begin
                        set_m(i, 1'b0, 1'b0, 13'h0, 4'h0, 32'h0);
                    end
                end
            end
            mem_reset_req = ($urandom_range(0, 9) == 0);
            #2;
            n_tests++; if (s_waitrequest !== exp_wait || s_readdatavalid !== exp_rdv) begin
                n_fail++; $display("FAIL rnd_ctl cyc %0d wait %b rdv %b want %b/%b", cyc, s_waitrequest, s_readdatavalid, exp_wait, exp_rdv); end
            n_tests++; if (mem_chipselect !== exp_cs || mem_write !== exp_we || mem_address !== exp_addr ||
                           mem_byteenable !== exp_be || mem_writedata !== exp_wd || mem_clken !== !mem_reset_req) begin
                n_fail++; $display("FAIL rnd_mem cyc %0d cs %b we %b a %h be %h wd %h want %b/%b/%h/%h/%h", cyc, mem_chipselect,
                                   mem_write, mem_address, mem_byteenable, mem_writedata, exp_cs, exp_we, exp_addr, exp_be, exp_wd); end
            if (exp_rdv != '0) begin
                n_tests++; if (s_readdata !== m_data) begin
                    n_fail++; $display("FAIL rnd_data cyc %0d got %h want %h", cyc, s_readdata, m_data); end
            end
            if (exp_g >= 0) act[exp_g] = 1'b0;
        end
        @(negedge clk); clr_all(); mem_reset_req = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        mem_reset_req = 1'b0;
        clr_all();
        test_reset();
        test_single_write_read();
        test_round_robin();
        test_byte_lane();
        test_simultaneous();
        test_mem_reset_req();
        test_reset_mid_read();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish within 200000 time units");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/core8_mem_arbiter.md
Name: core8_mem_arbiter

Overview:
- Shares one single-port 8192x32 on-chip memory (13-bit word address, 4 byte lanes, 1-cycle read latency, unregistered q) between NUM_MASTERS Avalon-MM requesters, e.g. cores in the 8-core cluster.
- Round-robin arbitration; at most one access issued per cycle; read data routed back to the issuing master.
- Sits between the core data masters and the memory slave port; honours the memory's reset_req clock-enable gating.

Parameters:
- NUM_MASTERS, 4, number of requesters (2..8).
- ADDR_W, 13, word address width.
- DATA_W, 32, data width; byte lanes = DATA_W/8.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-high reset
- mem_reset_req  in  1  memory reset request; blocks grants while high
- s_address  in  NUM_MASTERS*ADDR_W  per-master word address, master i at slice [i*ADDR_W +: ADDR_W]
- s_byteenable  in  NUM_MASTERS*4  per-master byte enables
- s_read  in  NUM_MASTERS  per-master read request
- s_write  in  NUM_MASTERS  per-master write request
- s_writedata  in  NUM_MASTERS*DATA_W  per-master write data
- s_waitrequest  out  NUM_MASTERS  high = request not accepted this cycle
- s_readdata  out  DATA_W  shared read data bus
- s_readdatavalid  out  NUM_MASTERS  one-hot read return strobe
- mem_address  out  ADDR_W  to memory
- mem_byteenable  out  4  to memory
- mem_chipselect  out  1  to memory
- mem_write  out  1  to memory
- mem_writedata  out  DATA_W  to memory
- mem_clken  out  1  to memory clock enable
- mem_readdata  in  DATA_W  memory q, valid the cycle after a read is issued

Behaviour:
- req[i] = s_read[i] | s_write[i]. If a master asserts both, the access is treated as a write and the read is ignored.
- State: rr_ptr (log2 NUM_MASTERS), rd_pending, rd_owner. Reset values: rr_ptr = 0, rd_pending = 0, rd_owner = 0.
- Grant is combinational within the cycle. It goes to the first requesting master searching from rr_ptr upward, wrapping modulo NUM_MASTERS.
  - No grant while mem_reset_req = 1 or reset = 1.
- s_waitrequest[i] = req[i] & ~grant[i]. An idle master sees waitrequest = 0.
  - Masters hold their request stable until waitrequest = 0; a request is accepted in the cycle it is granted.
- Memory side with a grant: mem_address, mem_byteenable and mem_writedata are muxed from the granted master; mem_chipselect = 1; mem_write = granted write.
- Memory side with no grant: mem_chipselect = 0, mem_write = 0, mem_address = 0, mem_byteenable = 0, mem_writedata = 0.
- mem_clken = ~mem_reset_req.
- On any grant to master g: rr_ptr <= (g+1) mod NUM_MASTERS. With no grant, rr_ptr holds.
- Granted read issued in cycle T:
  - rd_pending <= 1 and rd_owner <= g at the edge ending T.
  - In cycle T+1: s_readdatavalid[rd_owner] = rd_pending, s_readdata = mem_readdata.
- rd_pending clears at the next edge unless a new read is granted. Back-to-back reads give one return per cycle with fixed latency 1.
- Reads and writes may interleave every cycle. A write in T+1 does not disturb the read returning in T+1.
- s_readdatavalid is all zero when rd_pending = 0. s_readdata passes mem_readdata through unconditionally.
- mem_reset_req asserted while rd_pending = 1:
  - rd_pending clears at the next edge and s_readdatavalid is forced to 0 in that cycle (memory clock frozen, data invalid).
  - The master re-issues after mem_reset_req deasserts.
- Asynchronous reset mid-read: the pending return is dropped and no readdatavalid is produced. All outputs return to the idle values above.
- Fairness: a continuously requesting master is granted within NUM_MASTERS cycles.

Test Plan:
- Single master 0 writes 0xDEADBEEF at address 0x0010 with byteenable 0xF, then reads 0x0010 → waitrequest 0 on both; s_readdatavalid = 0001 exactly one cycle after the read; s_readdata = 0xDEADBEEF.
- All 4 masters request reads of addresses 0x100+i continuously from rr_ptr = 0 → grants in order 0,1,2,3,0,…; each master gets one readdatavalid per 4 cycles carrying the data at its own address; no cycle without a grant.
- Byte-lane write: master 2 writes 0x000000AA with byteenable 0x1 over 0x11223344 at 0x1FFF (top address) → readback 0x112233AA.
- Masters 1 and 3 request in the same cycle with rr_ptr = 2 → master 3 granted first and s_waitrequest[1] = 1; master 1 granted next cycle; rr_ptr ends at 2.
- mem_reset_req pulsed for 3 cycles while master 0 read is pending and master 1 requests → no readdatavalid in that window; mem_clken = 0; s_waitrequest[1] = 1 throughout; master 1 granted the cycle after deassertion.
- Assert reset in the cycle after a read grant → s_readdatavalid stays 0; mem_chipselect = 0; rr_ptr = 0 after release.
